// File: rtl/popcount_pkg.sv
// Shared types and defaults for the popcount sequencer.
// Optional feature macro: DEBOUNCE_EN (inserts start_debounce after the synchronizer).
package popcount_pkg;

  localparam int unsigned DEFAULT_DATA_W          = 8;
  localparam int unsigned DEFAULT_CNT_W           = 5;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 12000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/start_debounce.sv
// Stability filter for the synchronized start level.
// Output follows the input only after it has differed for CYCLES consecutive clocks.
module start_debounce
  import popcount_pkg::*;
#(
  parameter int unsigned CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b1;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/popcount_sequencer.sv
// Handshaked serial ones-counter: latches data_in on a start edge, counts one bit
// per clock and holds the result on count until the next run.
// Optional feature macro: DEBOUNCE_EN (debounces start after the synchronizer).
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter int unsigned DATA_W          = DEFAULT_DATA_W,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Elaboration-time parameter sanity checks.
  if ((2 ** CNT_W) <= DATA_W) begin : g_bad_cnt_w
    $error("popcount_sequencer: CNT_W too narrow for DATA_W");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("popcount_sequencer: DEBOUNCE_CYCLES must be at least 1");
  end

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic              start_s;
  logic              start_prev;
  logic              req;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  acc;
  logic [IDX_W-1:0]  idx;

  // Two-flop synchronizer; reset high so a start held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= start;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  start_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_start_debounce (
    .clk (clk),
    .rst (rst),
    .din (sync2),
    .dout(start_s)
  );
`else
  assign start_s = sync2;
`endif

  // Previous start level for rising-edge detection; tracks even while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_prev <= 1'b1;
    end else begin
      start_prev <= start_s;
    end
  end

  assign req = start_s & ~start_prev;

  // Sequencer: accept, scan one bit per cycle, publish result with a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      acc       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            shift_reg <= data_in;
            acc       <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          acc       <= acc + CNT_W'(shift_reg[0]);
          shift_reg <= shift_reg >> 1;
          idx       <= idx + IDX_W'(1);
          if (idx == IDX_W'(DATA_W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          count <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Randomized + directed bench for popcount_sequencer against a timeline model.
// Build with +define+DEBOUNCE_EN to exercise the debounced start path (16 cycles).
module tb_popcount_sequencer;

  localparam int DW = 8;
  localparam int CW = 5;
  localparam int DB = 16;
`ifdef DEBOUNCE_EN
  localparam int LAT   = 2 + DB;
  localparam int PULSE = 20;
  localparam int MAXP  = 25;
`else
  localparam int LAT   = 2;
  localparam int PULSE = 1;
  localparam int MAXP  = 4;
`endif
  localparam int RUN_WAIT = LAT + DW + 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] data_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  popcount_sequencer #(
    .DATA_W(DW),
    .CNT_W(CW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data_in(data_in),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: start history, acceptance rule and per-run timeline.
  bit model_valid = 0;
  bit h0, h1, h2;
  bit db, db1, db2;
  int db_run;
  bit active;
  int k;
  int pend;
  bit req_m;
  int e_busy, e_done, e_count;
  int e_runs   = 0;
  int dut_runs = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      h0 = 1; h1 = 1; h2 = 1;
      db = 1; db1 = 1; db2 = 1; db_run = 0;
      active = 0; k = 0;
      e_busy = 0; e_done = 0; e_count = 0;
      model_valid = 1;
    end else begin
`ifdef DEBOUNCE_EN
      req_m = db1 & ~db2;
`else
      req_m = h1 & ~h2;
`endif
      e_done = 0;
      if (active) begin
        k++;
        if (k == DW + 1) begin
          active  = 0;
          e_busy  = 0;
          e_done  = 1;
          e_count = pend;
          e_runs++;
        end
      end else if (req_m) begin
        active = 1;
        k      = 0;
        pend   = $countones(data_in);
        e_busy = 1;
      end
`ifdef DEBOUNCE_EN
      if (h1 != db) begin
        db_run++;
        if (db_run == DB) begin
          db     = h1;
          db_run = 0;
        end
      end else begin
        db_run = 0;
      end
      db2 = db1;
      db1 = db;
`endif
      h2 = h1;
      h1 = h0;
      h0 = start;
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("count", count, e_count);
      if (done) dut_runs++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic run_one(input logic [DW-1:0] d);
    data_in = d;
    start   = 1'b1;
    tick(PULSE);
    start = 1'b0;
    tick(RUN_WAIT);
  endtask

  int r0;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    tick(3);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);

    // Idle with no start edge.
    r0 = dut_runs;
    tick(50);
    check("idle_runs", dut_runs - r0, 0);
    check("idle_count", count, 0);

    // Basic run; data changes after acceptance must not matter.
    r0      = dut_runs;
    data_in = 8'b1011_0110;
    start   = 1'b1;
    tick(PULSE);
    start = 1'b0;
    tick(LAT + 2 - PULSE);
    data_in = 8'hFF;
    tick(RUN_WAIT);
    check("basic_count", count, 5);
    check("basic_runs", dut_runs - r0, 1);
    tick(20);
    check("basic_hold", count, 5);

    // Boundaries.
    r0 = dut_runs;
    run_one(8'h00);
    check("zero_count", count, 0);
    run_one(8'hFF);
    check("full_count", count, 8);
    check("bound_runs", dut_runs - r0, 2);

    // Toggle start during SCAN.
    r0      = dut_runs;
    data_in = 8'h0F;
    start   = 1'b1;
    tick(PULSE);
    start = 1'b0;
    tick(LAT + 1);
    start = 1'b1; tick(1);
    start = 1'b0; tick(1);
    start = 1'b1; tick(1);
    start = 1'b0;
    tick(RUN_WAIT);
    check("toggle_runs", dut_runs - r0, 1);
    check("toggle_count", count, 4);

    // Held start gives a single run.
    r0      = dut_runs;
    data_in = 8'h81;
    start   = 1'b1;
    tick(40);
    start = 1'b0;
    tick(RUN_WAIT);
    check("held_runs", dut_runs - r0, 1);
    check("held_count", count, 2);

    // Start held high through reset release.
    r0    = dut_runs;
    start = 1'b1;
    do_reset(3);
    tick(30);
    check("thru_rst_runs", dut_runs - r0, 0);
    start = 1'b0;
    tick(LAT + 6);
    run_one(8'h07);
    check("thru_rst_rerun", dut_runs - r0, 1);
    check("thru_rst_count", count, 3);

    // Reset at the 4th SCAN cycle aborts the run.
    r0      = dut_runs;
    data_in = 8'hFF;
    start   = 1'b1;
    tick(PULSE);
    start = 1'b0;
    tick(LAT + 4 - PULSE);
    rst = 1'b1;
    tick(1);
    check("midrun_busy", busy, 0);
    check("midrun_count", count, 0);
    check("midrun_done", done, 0);
    rst = 1'b0;
    tick(RUN_WAIT);
    check("midrun_runs", dut_runs - r0, 0);
    run_one(8'hFF);
    check("after_abort_count", count, 8);

`ifdef DEBOUNCE_EN
    // Bouncing start, then a clean hold: one run, accepted LAT after the last edge.
    r0    = dut_runs;
    data_in = 8'h3C;
    start = 1'b0;
    tick(30);
    for (int i = 0; i < 12; i++) begin
      start = ~start;
      tick(5);
    end
    start = 1'b1;
    tick(LAT);
    check("db_not_yet", busy, 0);
    tick(1);
    check("db_accept", busy, 1);
    tick(30);
    start = 1'b0;
    tick(RUN_WAIT);
    check("db_runs", dut_runs - r0, 1);
    check("db_count", count, 4);
`endif

    // Randomized runs with occasional resets.
    for (int i = 0; i < 40; i++) begin
      data_in = DW'($urandom);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2));
      start = 1'b1;
      tick($urandom_range(1, MAXP));
      start = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, 6));
        data_in = DW'($urandom);
      end
      tick($urandom_range(0, RUN_WAIT));
    end
    start = 1'b0;
    tick(RUN_WAIT + 10);
    check("total_runs", dut_runs, e_runs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
